// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - request/status bundle between the fetch stage and the PC unit
interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int SHIFT     = 2
);
  logic                      Stall;
  logic                      Branch;
  logic [IMM_WIDTH-1:0]      Imm;
  logic                      Jump;
  logic [WIDTH-4-SHIFT-1:0]  JumpIndex;
  logic                      JumpReg;
  logic [WIDTH-1:0]          RegTarget;
  logic [WIDTH-1:0]          Pc;
  logic [WIDTH-1:0]          PcNext;
  logic [WIDTH-1:0]          BranchTarget;
  logic                      Redirected;
  logic                      Misaligned;
  logic                      Pending;

  // Pipeline side: raises stall/redirect requests, observes the PC state
  modport master (
    output Stall, Branch, Imm, Jump, JumpIndex, JumpReg, RegTarget,
    input  Pc, PcNext, BranchTarget, Redirected, Misaligned, Pending
  );

  // PC unit side
  modport slave (
    input  Stall, Branch, Imm, Jump, JumpIndex, JumpReg, RegTarget,
    output Pc, PcNext, BranchTarget, Redirected, Misaligned, Pending
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered, stall-aware program counter with buffered redirects
module pc_unit #(
  parameter int             WIDTH        = 32,
  parameter int             IMM_WIDTH    = 16,
  parameter int             SHIFT        = 2,
  parameter int             STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic     Clk,
  input logic     Reset,
  pc_unit_if.slave bus
);
  localparam logic MIS_RESET = |RESET_VECTOR[SHIFT-1:0];

  logic [WIDTH-1:0] pcQ;
  logic [WIDTH-1:0] pcD;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] sextImm;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] jumpTarget;
  logic [WIDTH-1:0] reqTarget;
  logic [WIDTH-1:0] pendTargetQ;
  logic [WIDTH-1:0] pendTargetD;
  logic             pendValidQ;
  logic             pendValidD;
  logic             redirectedQ;
  logic             redirectedD;
  logic             misalignedQ;
  logic             request;

  // Sequential/branch/jump targets and the prioritised redirect target
  always_comb begin
    pcNext       = pcQ + WIDTH'(STEP);
    sextImm      = {{(WIDTH-IMM_WIDTH){bus.Imm[IMM_WIDTH-1]}}, bus.Imm};
    branchTarget = pcNext + (sextImm << SHIFT);
    jumpTarget   = {pcNext[WIDTH-1:WIDTH-4], bus.JumpIndex, {SHIFT{1'b0}}};
    request      = bus.JumpReg | bus.Jump | bus.Branch;
    if (bus.JumpReg) begin
      reqTarget = bus.RegTarget;
    end else if (bus.Jump) begin
      reqTarget = jumpTarget;
    end else begin
      reqTarget = branchTarget;
    end
  end

  // Next-PC selection: stall buffers the latest request, release applies it
  always_comb begin
    pcD         = pcNext;
    redirectedD = 1'b0;
    pendValidD  = pendValidQ;
    pendTargetD = pendTargetQ;
    if (bus.Stall) begin
      pcD = pcQ;
      if (request) begin
        pendValidD  = 1'b1;
        pendTargetD = reqTarget;
      end
    end else if (request) begin
      pcD         = reqTarget;
      redirectedD = 1'b1;
      pendValidD  = 1'b0;
    end else if (pendValidQ) begin
      pcD         = pendTargetQ;
      redirectedD = 1'b1;
      pendValidD  = 1'b0;
    end
  end

  // PC and status registers; reset discards any buffered redirect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pcQ         <= RESET_VECTOR;
      pendValidQ  <= 1'b0;
      redirectedQ <= 1'b0;
      misalignedQ <= MIS_RESET;
    end else begin
      pcQ         <= pcD;
      pendValidQ  <= pendValidD;
      redirectedQ <= redirectedD;
      misalignedQ <= |pcD[SHIFT-1:0];
    end
  end

  // Buffered target needs no reset; it is only used while pendValidQ is set
  always_ff @(posedge Clk) begin
    pendTargetQ <= pendTargetD;
  end

  assign bus.Pc           = pcQ;
  assign bus.PcNext       = pcNext;
  assign bus.BranchTarget = branchTarget;
  assign bus.Redirected   = redirectedQ;
  assign bus.Misaligned   = misalignedQ;
  assign bus.Pending      = pendValidQ;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed-vector bench for pc_unit
module tb_pc_unit;
  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  pc_unit_if #(.WIDTH(32), .IMM_WIDTH(16), .SHIFT(2)) bus ();

  pc_unit #(
    .WIDTH(32), .IMM_WIDTH(16), .SHIFT(2), .STEP(4), .RESET_VECTOR(32'h0)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReq();
    bus.Branch  = 1'b0;
    bus.Jump    = 1'b0;
    bus.JumpReg = 1'b0;
  endtask

  // Load an arbitrary PC through the jump-register path
  task automatic loadPc(input logic [31:0] target);
    clearReq();
    bus.JumpReg   = 1'b1;
    bus.RegTarget = target;
    step();
    clearReq();
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    reset         = 1'b1;
    bus.Stall     = 1'b0;
    bus.Imm       = '0;
    bus.JumpIndex = '0;
    bus.RegTarget = '0;
    clearReq();
    step();
    // Request during reset must be ignored
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0100;
    step();
    clearReq();
    checkEq("reset_pc", bus.Pc, 32'h0);
    checkEq("reset_redirected", {31'b0, bus.Redirected}, 32'h0);
    checkEq("reset_pending", {31'b0, bus.Pending}, 32'h0);
    checkEq("reset_misaligned", {31'b0, bus.Misaligned}, 32'h0);
    reset = 1'b0;
    #1;
    checkEq("reset_pcnext", bus.PcNext, 32'h4);

    // Sequential fetch
    step();
    checkEq("seq_pc_4", bus.Pc, 32'h4);
    checkEq("seq_pcnext_8", bus.PcNext, 32'h8);
    step();
    checkEq("seq_pc_8", bus.Pc, 32'h8);
    step();
    checkEq("seq_pc_c", bus.Pc, 32'hC);
    checkEq("seq_redirected", {31'b0, bus.Redirected}, 32'h0);
    step();
    checkEq("seq_pc_10", bus.Pc, 32'h10);

    // Forward branch
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0110;
    #1;
    checkEq("br_target_comb", bus.BranchTarget, 32'h454);
    step();
    clearReq();
    checkEq("br_pc", bus.Pc, 32'h454);
    checkEq("br_redirected", {31'b0, bus.Redirected}, 32'h1);
    step();
    checkEq("br_after_pc", bus.Pc, 32'h458);
    checkEq("br_after_redirected", {31'b0, bus.Redirected}, 32'h0);

    // Negative branch offset: -1 instruction from PcNext lands on Pc
    loadPc(32'h100);
    checkEq("jr_pc_100", bus.Pc, 32'h100);
    bus.Branch = 1'b1;
    bus.Imm    = 16'hFFFF;
    #1;
    checkEq("brneg_target_comb", bus.BranchTarget, 32'h100);
    step();
    clearReq();
    checkEq("brneg_pc", bus.Pc, 32'h100);

    // Wrap-around
    loadPc(32'hFFFF_FFFC);
    checkEq("wrap_pre_pc", bus.Pc, 32'hFFFF_FFFC);
    checkEq("wrap_pcnext", bus.PcNext, 32'h0);
    step();
    checkEq("wrap_pc", bus.Pc, 32'h0);
    checkEq("wrap_redirected", {31'b0, bus.Redirected}, 32'h0);

    // Priority: Jump over Branch, then JumpReg over both
    loadPc(32'h1000_0000);
    bus.Jump      = 1'b1;
    bus.JumpIndex = 26'h40;
    bus.Branch    = 1'b1;
    bus.Imm       = 16'h0005;
    step();
    checkEq("prio_jump_pc", bus.Pc, 32'h1000_0100);
    bus.JumpReg   = 1'b1;
    bus.RegTarget = 32'h0000_0102;
    step();
    clearReq();
    checkEq("prio_jr_pc", bus.Pc, 32'h102);
    checkEq("prio_jr_misaligned", {31'b0, bus.Misaligned}, 32'h1);
    step();
    checkEq("mis_seq_pc", bus.Pc, 32'h106);
    checkEq("mis_seq_misaligned", {31'b0, bus.Misaligned}, 32'h1);

    // Stall buffering of a single branch
    loadPc(32'h20);
    checkEq("stall_pre_misaligned", {31'b0, bus.Misaligned}, 32'h0);
    bus.Stall  = 1'b1;
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0004;
    step();
    clearReq();
    checkEq("stall1_pc", bus.Pc, 32'h20);
    checkEq("stall1_pending", {31'b0, bus.Pending}, 32'h1);
    checkEq("stall1_redirected", {31'b0, bus.Redirected}, 32'h0);
    step();
    step();
    checkEq("stall3_pc", bus.Pc, 32'h20);
    checkEq("stall3_pending", {31'b0, bus.Pending}, 32'h1);
    bus.Stall = 1'b0;
    step();
    checkEq("release_pc", bus.Pc, 32'h34);
    checkEq("release_pending", {31'b0, bus.Pending}, 32'h0);
    checkEq("release_redirected", {31'b0, bus.Redirected}, 32'h1);

    // Latest buffered request wins
    bus.Stall  = 1'b1;
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0004;
    step();
    clearReq();
    bus.Jump      = 1'b1;
    bus.JumpIndex = 26'h80;
    step();
    clearReq();
    step();
    checkEq("latest_stall_pc", bus.Pc, 32'h34);
    bus.Stall = 1'b0;
    step();
    checkEq("latest_release_pc", bus.Pc, 32'h200);
    checkEq("latest_redirected", {31'b0, bus.Redirected}, 32'h1);

    // A new request at release discards the buffered one
    bus.Stall  = 1'b1;
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0008;
    step();
    clearReq();
    bus.Stall     = 1'b0;
    bus.JumpReg   = 1'b1;
    bus.RegTarget = 32'h300;
    step();
    clearReq();
    checkEq("newreq_pc", bus.Pc, 32'h300);
    checkEq("newreq_pending", {31'b0, bus.Pending}, 32'h0);
    step();
    checkEq("newreq_after_pc", bus.Pc, 32'h304);

    // Reset during a stall with a buffered redirect
    bus.Stall  = 1'b1;
    bus.Branch = 1'b1;
    bus.Imm    = 16'h0008;
    step();
    checkEq("rststall_pending", {31'b0, bus.Pending}, 32'h1);
    reset = 1'b1;
    step();
    checkEq("rststall_pc", bus.Pc, 32'h0);
    checkEq("rststall_pending_clr", {31'b0, bus.Pending}, 32'h0);
    reset = 1'b0;
    clearReq();
    bus.Stall = 1'b0;
    step();
    checkEq("rststall_release_pc", bus.Pc, 32'h4);
    checkEq("rststall_release_redir", {31'b0, bus.Redirected}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
